// File: rtl/leiwand_rv32_timer_irq_pkg.sv
// ============================================================================
// Module   : leiwand_rv32_timer_irq_pkg
// Brief    : Shared constants, bus FSM states and byte-merge helper for the
//            leiwand_rv32 machine timer / interrupt responder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package leiwand_rv32_timer_irq_pkg;

  localparam int c_MEM_WIDTH = 32;

  // Word offsets, decoded from addr[7:2]
  localparam logic [5:0] c_TIMER_MTIME_LO    = 6'h00;
  localparam logic [5:0] c_TIMER_MTIME_HI    = 6'h01;
  localparam logic [5:0] c_TIMER_MTIMECMP_LO = 6'h02;
  localparam logic [5:0] c_TIMER_MTIMECMP_HI = 6'h03;
  localparam logic [5:0] c_TIMER_MSIP        = 6'h04;
  localparam logic [5:0] c_TIMER_IRQ_STATUS  = 6'h05;

  localparam int c_IRQ_SOFT_BIT  = 0;
  localparam int c_IRQ_TIMER_BIT = 1;

  typedef enum logic [0:0] {
    BUS_IDLE = 1'b0,
    BUS_ACK  = 1'b1
  } bus_state_t;

  function automatic logic [c_MEM_WIDTH-1:0] byte_merge(
    input logic [c_MEM_WIDTH-1:0] old_val,
    input logic [c_MEM_WIDTH-1:0] new_val,
    input logic [3:0]             be
  );
    logic [c_MEM_WIDTH-1:0] r;
    r = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_val[8*i +: 8];
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/leiwand_rv32_timer_irq_prescaler.sv
// ============================================================================
// Module   : leiwand_rv32_timer_prescaler
// Brief    : Free-running divider producing a one-cycle tick every PRESCALE
//            clocks (PRESCALE=1 ticks every cycle).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module leiwand_rv32_timer_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int                 c_CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(PRESCALE - 1);

  logic [c_CNT_W-1:0] r_cnt;

  assign tick = (r_cnt == c_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/leiwand_rv32_timer_irq.sv
// ============================================================================
// Module   : leiwand_rv32_timer_irq
// Brief    : Memory-mapped mtime/mtimecmp/msip responder with timer and
//            software IRQ outputs. LEIWAND_RV32_TIMER_SNAPSHOT_EN adds a
//            coherent MTIME_HI shadow latched by MTIME_LO reads.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module leiwand_rv32_timer_irq
  import leiwand_rv32_timer_irq_pkg::*;
#(
  parameter int          PRESCALE     = 1,
  parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   valid,
  output logic                   ready,
  input  logic [3:0]             wen,
  input  logic [c_MEM_WIDTH-1:0] addr,
  input  logic [c_MEM_WIDTH-1:0] wdata,
  output logic [c_MEM_WIDTH-1:0] rdata,
  output logic                   timer_irq,
  output logic                   soft_irq,
  output logic [c_MEM_WIDTH-1:0] irq_status
);

  bus_state_t             r_state;
  bus_state_t             w_next_state;
  logic                   w_access;
  logic                   w_wr;
  logic                   w_rd;
  logic [5:0]             w_off;
  logic                   w_tick;
  logic [63:0]            r_mtime;
  logic [63:0]            r_mtimecmp;
  logic                   r_msip;
  logic [c_MEM_WIDTH-1:0] r_rdata;
  logic [c_MEM_WIDTH-1:0] w_rdata;
  logic [c_MEM_WIDTH-1:0] w_mtime_hi_rd;
  logic                   w_unused;

  assign w_off    = addr[7:2];
  assign w_unused = ^{addr[31:8], addr[1:0]};
  assign w_wr     = w_access & (|wen);
  assign w_rd     = w_access & ~(|wen);
  assign ready    = (r_state == BUS_ACK);
  assign rdata    = r_rdata;

  leiwand_rv32_timer_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .tick  (w_tick)
  );

  // The access commits on the same edge that raises ready.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= BUS_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_access     = 1'b0;
    case (r_state)
      BUS_IDLE: begin
        if (valid) begin
          w_next_state = BUS_ACK;
          w_access     = 1'b1;
        end
      end
      BUS_ACK:  w_next_state = BUS_IDLE;
      default:  w_next_state = BUS_IDLE;
    endcase
  end

`ifdef LEIWAND_RV32_TIMER_SNAPSHOT_EN
  logic [31:0] r_shadow;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shadow <= '0;
    end else if (w_wr && (w_off == c_TIMER_MTIME_HI)) begin
      r_shadow <= byte_merge(r_mtime[63:32], wdata, wen);
    end else if (w_rd && (w_off == c_TIMER_MTIME_LO)) begin
      r_shadow <= r_mtime[63:32];
    end
  end

  assign w_mtime_hi_rd = r_shadow;
`else
  assign w_mtime_hi_rd = r_mtime[63:32];
`endif

  always_comb begin
    w_rdata = '0;
    case (w_off)
      c_TIMER_MTIME_LO:    w_rdata = r_mtime[31:0];
      c_TIMER_MTIME_HI:    w_rdata = w_mtime_hi_rd;
      c_TIMER_MTIMECMP_LO: w_rdata = r_mtimecmp[31:0];
      c_TIMER_MTIMECMP_HI: w_rdata = r_mtimecmp[63:32];
      c_TIMER_MSIP:        w_rdata = {31'b0, r_msip};
      c_TIMER_IRQ_STATUS:  w_rdata = irq_status;
      default:             w_rdata = '0;
    endcase
  end

  // A bus write to either mtime half suppresses that cycle's increment entirely.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mtime <= '0;
    end else if (w_wr && (w_off == c_TIMER_MTIME_LO)) begin
      r_mtime[31:0] <= byte_merge(r_mtime[31:0], wdata, wen);
    end else if (w_wr && (w_off == c_TIMER_MTIME_HI)) begin
      r_mtime[63:32] <= byte_merge(r_mtime[63:32], wdata, wen);
    end else if (w_tick) begin
      r_mtime <= r_mtime + 64'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mtimecmp <= MTIMECMP_RST;
      r_msip     <= 1'b0;
    end else if (w_wr) begin
      case (w_off)
        c_TIMER_MTIMECMP_LO: r_mtimecmp[31:0]  <= byte_merge(r_mtimecmp[31:0], wdata, wen);
        c_TIMER_MTIMECMP_HI: r_mtimecmp[63:32] <= byte_merge(r_mtimecmp[63:32], wdata, wen);
        c_TIMER_MSIP:        if (wen[0]) r_msip <= wdata[0];
        default:             ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rdata   <= '0;
      timer_irq <= 1'b0;
      soft_irq  <= 1'b0;
    end else begin
      r_rdata   <= w_rd ? w_rdata : '0;
      timer_irq <= (r_mtime >= r_mtimecmp);
      soft_irq  <= r_msip;
    end
  end

  always_comb begin
    irq_status                  = '0;
    irq_status[c_IRQ_TIMER_BIT] = timer_irq;
    irq_status[c_IRQ_SOFT_BIT]  = soft_irq;
  end

endmodule

`default_nettype wire

// File: tb/tb_leiwand_rv32_timer_irq.sv
// ============================================================================
// Module   : tb_leiwand_rv32_timer_irq
// Brief    : Randomized self-checking bench; mtime is modelled as a closed-form
//            function of clock edges since the last mtime write.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_leiwand_rv32_timer_irq;

  localparam int P = 4;

  logic        clk    = 1'b0;
  logic        reset  = 1'b0;
  logic        valid  = 1'b0;
  logic [3:0]  wen    = 4'h0;
  logic [31:0] addr   = '0;
  logic [31:0] wdata  = '0;
  logic        ready;
  logic [31:0] rdata;
  logic        timer_irq;
  logic        soft_irq;
  logic [31:0] irq_status;

  always #5 clk = ~clk;

  leiwand_rv32_timer_irq #(
    .PRESCALE     (P),
    .MTIMECMP_RST (64'hFFFF_FFFF_FFFF_FFFF)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .valid      (valid),
    .ready      (ready),
    .wen        (wen),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .timer_irq  (timer_irq),
    .soft_irq   (soft_irq),
    .irq_status (irq_status)
  );

  // Edges since reset release; mtime ticks on edges that are multiples of P.
  int edge_n;
  always @(posedge clk or negedge reset) begin
    if (!reset) edge_n <= 0;
    else        edge_n <= edge_n + 1;
  end

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  logic [63:0] m_base, m_cmp, m_cmp_prev;
  int          m_edge, m_cmp_edge;
  logic        m_msip;
  logic [31:0] m_shadow;

  task automatic model_reset();
    m_base     = '0;
    m_edge     = 0;
    m_cmp      = 64'hFFFF_FFFF_FFFF_FFFF;
    m_cmp_prev = m_cmp;
    m_cmp_edge = 0;
    m_msip     = 1'b0;
    m_shadow   = '0;
  endtask

  function automatic logic [63:0] mtime_after(input int n);
    if (n < 0) return 64'd0;
    return m_base + 64'(n / P - m_edge / P);
  endfunction

  function automatic logic [63:0] cmp_at(input int n);
    return (n >= m_cmp_edge) ? m_cmp : m_cmp_prev;
  endfunction

  function automatic logic timer_after(input int n);
    if (n < 1) return 1'b0;
    return mtime_after(n - 1) >= cmp_at(n - 1);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] wd,
                                        input logic [3:0] we);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) if (we[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  task automatic bus(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd);
    logic [31:0] exp;
    logic [63:0] cur;
    logic [31:0] nh;
    logic        got;
    int          e;
    @(negedge clk);
    valid = 1'b1; addr = a; wen = we; wdata = wd;
    got = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin
      @(negedge clk);
      got = ready;
    end
    if (!got) begin
      check("bus_ack_timeout", 64'd0, 64'd1);
      valid = 1'b0; wen = 4'h0;
      return;
    end
    e   = edge_n;
    cur = mtime_after(e - 1);
    exp = '0;
    case (a[7:2])
      6'd0: exp = cur[31:0];
`ifdef LEIWAND_RV32_TIMER_SNAPSHOT_EN
      6'd1: exp = m_shadow;
`else
      6'd1: exp = cur[63:32];
`endif
      6'd2: exp = m_cmp[31:0];
      6'd3: exp = m_cmp[63:32];
      6'd4: exp = {31'b0, m_msip};
      6'd5: exp = {30'b0, timer_after(e - 1), m_msip};
      default: exp = '0;
    endcase
    if (we == 4'h0) begin
      check($sformatf("rd_%02h", a[7:0]), rdata, exp);
`ifdef LEIWAND_RV32_TIMER_SNAPSHOT_EN
      if (a[7:2] == 6'd0) m_shadow = cur[63:32];
`endif
    end else begin
      case (a[7:2])
        6'd0: begin m_base = {cur[63:32], merge(cur[31:0], wd, we)}; m_edge = e; end
        6'd1: begin
          nh = merge(cur[63:32], wd, we);
          m_base = {nh, cur[31:0]}; m_edge = e;
          m_shadow = nh;
        end
        6'd2: begin m_cmp_prev = m_cmp; m_cmp[31:0]  = merge(m_cmp[31:0], wd, we);  m_cmp_edge = e; end
        6'd3: begin m_cmp_prev = m_cmp; m_cmp[63:32] = merge(m_cmp[63:32], wd, we); m_cmp_edge = e; end
        6'd4: if (we[0]) m_msip = wd[0];
        default: ;
      endcase
    end
    valid = 1'b0; wen = 4'h0;
  endtask

  task automatic idle(input int k);
    int n;
    logic t;
    repeat (k) begin
      @(negedge clk);
      n = edge_n;
      t = timer_after(n);
      check("timer_irq", timer_irq, t);
      check("soft_irq", soft_irq, m_msip);
      check("irq_status", irq_status, {30'b0, t, m_msip});
      check("ready_idle", ready, 1'b0);
      check("rdata_idle", rdata, 32'h0);
    end
  endtask

  logic [31:0] offs [8] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'hFC};
  logic [31:0] rnd;
  logic [31:0] a;
  logic [3:0]  we;
  logic [31:0] wd;
  int          waited;

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", ready, 1'b0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_timer_irq", timer_irq, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    bus(32'h08, 4'h0, 32'h0);
    bus(32'h0C, 4'h0, 32'h0);

    idle(40);
    bus(32'h00, 4'h0, 32'h0);
    idle(1);

    // low-word carry into the high word
    bus(32'h00, 4'hF, 32'hFFFF_FFFE);
    bus(32'h04, 4'hF, 32'h0);
    idle(12);
    bus(32'h04, 4'h0, 32'h0);
    bus(32'h00, 4'h0, 32'h0);

    // timer compare rise, then push compare away
    bus(32'h0C, 4'hF, 32'h0);
    bus(32'h08, 4'hF, 32'h20);
    bus(32'h04, 4'hF, 32'h0);
    bus(32'h00, 4'hF, 32'h0);
    waited = 0;
    while (!timer_irq && waited < 300) begin
      idle(1);
      waited++;
    end
    check("timer_irq_rise", timer_irq, 1'b1);
    idle(2);
    bus(32'h14, 4'h0, 32'h0);
    bus(32'h0C, 4'hF, 32'h1);
    idle(1);
    check("timer_irq_drop", timer_irq, 1'b0);

    // msip byte enables
    bus(32'h10, 4'b0001, 32'h1);
    idle(2);
    bus(32'h10, 4'b0010, 32'h0);
    idle(2);
    bus(32'h10, 4'h0, 32'h0);
    bus(32'h14, 4'h0, 32'h0);

    // coherent high-word read across a carry
    bus(32'h04, 4'hF, 32'h0);
    bus(32'h00, 4'hF, 32'hFFFF_FFF0);
    bus(32'h00, 4'h0, 32'h0);
    idle(80);
    bus(32'h04, 4'h0, 32'h0);

    for (int i = 0; i < 100; i++) begin
      rnd = $urandom;
      a   = {rnd[31:8], offs[$urandom_range(0, 7)][7:0]};
      we  = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(1, 15));
      wd  = $urandom;
      if ($urandom_range(0, 1) == 1) wd = $urandom_range(0, 96);
      bus(a, we, wd);
      idle($urandom_range(0, 4));
    end

    // reset during a pending write
    @(negedge clk);
    valid = 1'b1; addr = 32'h08; wen = 4'hF; wdata = 32'h1234;
    #2 reset = 1'b0;
    valid = 1'b0; wen = 4'h0;
    @(posedge clk);
    #1;
    check("midrst_ready", ready, 1'b0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    bus(32'h08, 4'h0, 32'h0);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
